lfsr_16: RTL and testbench



---
 rtl/lfsr_16_pkg.sv | 15 +
 rtl/lfsr_16_next.sv | 12 +
 rtl/lfsr_16.sv | 40 ++++
 tb/tb_lfsr_16.sv | 133 +++++++++++++
 4 files changed

// File: rtl/lfsr_16_pkg.sv
// lfsr_16_pkg: shared width, default seed/taps and next-state function for lfsr_16.
package lfsr_16_pkg;
    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h0001;
    localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 16'hB400;

    // An all-zero state would lock the shifter, so it is replaced by the seed.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] taps,
        input logic [LFSR_W-1:0] seed
    );
        return (s == '0) ? seed : {s[LFSR_W-2:0], ^(s & taps)};
    endfunction
endpackage

// File: rtl/lfsr_16_next.sv
// lfsr_16_next: combinational Fibonacci step with lockup guard.
module lfsr_16_next
    import lfsr_16_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic [LFSR_W-1:0] state,
    input  logic [LFSR_W-1:0] taps,
    output logic [LFSR_W-1:0] nxt_state
);
    assign nxt_state = lfsr_next(state, taps, SEED);
endmodule

// File: rtl/lfsr_16.sv
// lfsr_16: 16-bit maximal-length Fibonacci LFSR with sync active-low reset.
// Define LFSR_16_SEED_LOAD_EN to add the load/seed_in reload ports.
module lfsr_16
    import lfsr_16_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
`ifdef LFSR_16_SEED_LOAD_EN
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
`endif
    output logic [LFSR_W-1:0] lfsr
);
    logic [LFSR_W-1:0] nxt;

    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_16: SEED must be nonzero");
    end

    lfsr_16_next #(.SEED(SEED)) u_next (
        .state     (lfsr),
        .taps      (TAPS),
        .nxt_state (nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            lfsr <= SEED;
`ifdef LFSR_16_SEED_LOAD_EN
        else if (load)
            lfsr <= (seed_in == '0) ? SEED : seed_in;
`endif
        else if (enable)
            lfsr <= nxt;
    end
endmodule

// File: tb/tb_lfsr_16.sv
// tb_lfsr_16: vector table, random run against a reference model, and full-period check.
module tb_lfsr_16;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        enable = 0;
    logic        load = 0;
    logic [15:0] seed_in = 0;
    logic [15:0] lfsr;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_16 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
`ifdef LFSR_16_SEED_LOAD_EN
        .load    (load),
        .seed_in (seed_in),
`endif
        .lfsr    (lfsr)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] exp;
    } vec_t;

    function automatic logic [15:0] model_next(input logic [15:0] s);
        int fb;
        if (s == 0) return 16'h0001;
        fb = ((s >> 15) + (s >> 13) + (s >> 12) + (s >> 10)) % 2;
        return 16'((s * 2) % 65536 + fb);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        reset_n = r;
        enable = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[$];
        logic [15:0] exp;
        bit seen_zero, seen_seed;
        vt = '{
            '{0, 0, 16'h0001}, '{0, 0, 16'h0001}, '{1, 0, 16'h0001}, '{1, 0, 16'h0001},
            '{1, 1, 16'h0002}, '{1, 1, 16'h0004}, '{1, 1, 16'h0008}, '{1, 1, 16'h0010},
            '{1, 1, 16'h0020}, '{1, 1, 16'h0040}, '{1, 1, 16'h0080}, '{1, 1, 16'h0100},
            '{1, 1, 16'h0200}, '{1, 1, 16'h0400},
            '{1, 0, 16'h0400}, '{1, 0, 16'h0400}, '{1, 0, 16'h0400}, '{1, 0, 16'h0400},
            '{1, 0, 16'h0400},
            '{1, 1, 16'h0801}, '{1, 1, 16'h1002},
            '{0, 1, 16'h0001}, '{1, 1, 16'h0002},
            '{1, 1, 16'h0004}, '{1, 1, 16'h0008}, '{1, 1, 16'h0010}, '{1, 1, 16'h0020},
            '{1, 1, 16'h0040}, '{1, 1, 16'h0080}, '{1, 1, 16'h0100}, '{1, 1, 16'h0200},
            '{1, 1, 16'h0400}, '{1, 1, 16'h0801}, '{1, 1, 16'h1002}, '{1, 1, 16'h2005},
            '{1, 1, 16'h400B}
        };
        foreach (vt[i]) begin
            step(vt[i].rst_n, vt[i].en);
            chk($sformatf("vec%0d", i), lfsr, vt[i].exp);
        end

        exp = 16'h400B;
        for (int i = 0; i < 40; i++) begin
            step(1, i[0]);
            if (i[0]) exp = model_next(exp);
            chk("toggle_en", lfsr, exp);
        end

        for (int i = 0; i < 2000; i++) begin
            logic r, e;
            r = ($urandom_range(0, 63) != 0);
            e = 1'($urandom);
            step(r, e);
            exp = !r ? 16'h0001 : (e ? model_next(exp) : exp);
            chk("random", lfsr, exp);
        end

`ifdef LFSR_16_SEED_LOAD_EN
        @(negedge clk);
        reset_n = 1; enable = 1; load = 1; seed_in = 16'h0400;
        @(posedge clk); #1;
        chk("load_0400", lfsr, 16'h0400);
        @(negedge clk);
        load = 0;
        @(posedge clk); #1;
        chk("after_load", lfsr, 16'h0801);
        @(negedge clk);
        load = 1; seed_in = 16'h0000;
        @(posedge clk); #1;
        chk("load_zero", lfsr, 16'h0001);
        @(negedge clk);
        load = 0;
`endif

        step(0, 1);
        chk("period_reset", lfsr, 16'h0001);
        seen_zero = 0;
        seen_seed = 0;
        @(negedge clk);
        reset_n = 1;
        enable = 1;
        for (int i = 1; i < 65535; i++) begin
            @(posedge clk);
            #1;
            if (lfsr === 16'h0000) seen_zero = 1;
            if (lfsr === 16'h0001) seen_seed = 1;
        end
        @(posedge clk);
        #1;
        chk("period_return", lfsr, 16'h0001);
        chk("period_no_zero", {15'd0, seen_zero}, 16'd0);
        chk("period_no_early_seed", {15'd0, seen_seed}, 16'd0);
        enable = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
